// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue queue: opcode encodings,
// default widths, the command record and the output-stage state type.
package alu_pkg;

    localparam int ALU_WORDSIZE  = 32;
    localparam int ALU_SEL_WIDTH = 4;
    localparam int ALU_TAG_WIDTH = 4;

    localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_MUL  = 4'b0010;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_DIV  = 4'b0011;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SHL  = 4'b0100;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SHR  = 4'b0101;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_ROL  = 4'b0110;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_ROR  = 4'b0111;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_AND  = 4'b1000;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_OR   = 4'b1001;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_NOR  = 4'b1010;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_NAND = 4'b1011;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_XOR  = 4'b1100;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_XNOR = 4'b1101;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_GT   = 4'b1110;
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_EQ   = 4'b1111;

    // One queued ALU operation at the default widths.
    typedef struct packed {
        logic [ALU_WORDSIZE-1:0]  a;
        logic [ALU_WORDSIZE-1:0]  y;
        logic [ALU_SEL_WIDTH-1:0] sel;
        logic [ALU_TAG_WIDTH-1:0] tag;
    } alu_cmd_t;

    // Registered result stage: holds nothing, or one result awaiting a consumer.
    typedef enum logic {
        OS_EMPTY = 1'b0,
        OS_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Command storage for the ALU issue queue: a DEPTH-entry circular buffer
// with occupancy count. Reads are combinational from the head entry.
module alu_issue_fifo #(
    parameter int DATA_W = 76,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry write on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only read once the count marks them valid.
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the combinational ALU: buffers commands, drives
// the head entry onto the ALU inputs and registers the tagged result.
// Optional: define ALU_ISSUE_BYPASS_EN to let a command arriving at an idle
// queue go straight to the output stage (1-edge latency).
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WORDSIZE  = ALU_WORDSIZE,
    parameter int SEL_WIDTH = ALU_SEL_WIDTH,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = ALU_TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORDSIZE-1:0]        in_a,
    input  logic [WORDSIZE-1:0]        in_y,
    input  logic [SEL_WIDTH-1:0]       in_sel,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic [WORDSIZE-1:0]        alu_a,
    output logic [WORDSIZE-1:0]        alu_y,
    output logic [SEL_WIDTH-1:0]       alu_sel,
    input  logic [WORDSIZE-1:0]        alu_result,
    input  logic                       alu_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDSIZE-1:0]        out_result,
    output logic                       out_carry,
    output logic                       out_divzero,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CMD_W = 2 * WORDSIZE + SEL_WIDTH + TAG_WIDTH;

    logic [CMD_W-1:0]     wr_data;
    logic [CMD_W-1:0]     head_data;
    logic [WORDSIZE-1:0]  head_a;
    logic [WORDSIZE-1:0]  head_y;
    logic [SEL_WIDTH-1:0] head_sel;
    logic [TAG_WIDTH-1:0] head_tag;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic [WORDSIZE-1:0]  src_a;
    logic [WORDSIZE-1:0]  src_y;
    logic [SEL_WIDTH-1:0] src_sel;
    logic [TAG_WIDTH-1:0] src_tag;

    out_state_t state_q;
    out_state_t state_d;

    logic stage_free;
    logic push;
    logic bypass;
    logic fifo_push;
    logic load_fifo;
    logic load;
    logic div_zero;

    assign wr_data = {in_a, in_y, in_sel, in_tag};
    assign {head_a, head_y, head_sel, head_tag} = head_data;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign stage_free = (state_q == OS_EMPTY) || out_ready;
    assign load_fifo  = !fifo_empty && stage_free;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass = fifo_empty && stage_free && push;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = push && !bypass;
    assign load      = load_fifo || bypass;

    alu_issue_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (load_fifo),
        .wr_data (wr_data),
        .rd_data (head_data),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Select the command presented to the ALU: head entry, the incoming command on bypass, or zeros when idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        src_a   = head_a;
        src_y   = head_y;
        src_sel = head_sel;
        src_tag = head_tag;
        alu_a   = fifo_empty ? '0 : head_a;
        alu_y   = fifo_empty ? '0 : head_y;
        alu_sel = fifo_empty ? '0 : head_sel;
`ifdef ALU_ISSUE_BYPASS_EN
        if (fifo_empty && stage_free) begin
            src_a   = in_a;
            src_y   = in_y;
            src_sel = in_sel;
            src_tag = in_tag;
            alu_a   = in_a;
            alu_y   = in_y;
            alu_sel = in_sel;
        end
`endif
    end

    assign div_zero = (src_sel == ALU_DIV) && (src_y == '0);

    // Output-stage state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= OS_EMPTY;
        else     state_q <= state_d;
    end

    // Output-stage next state: fill on load, drain when consumed with nothing to replace it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OS_EMPTY: if (load) state_d = OS_FULL;
            OS_FULL:  if (out_ready && !load) state_d = OS_EMPTY;
            default:  state_d = OS_EMPTY;
        endcase
    end

    assign out_valid = (state_q == OS_FULL);

    // Result capture; divide-by-zero saturates and carry is kept only for ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result  <= '0;
            out_carry   <= 1'b0;
            out_divzero <= 1'b0;
            out_tag     <= '0;
        end else if (load) begin
            out_result  <= div_zero ? '1 : alu_result;
            out_divzero <= div_zero;
            out_carry   <= (src_sel == ALU_ADD) && alu_carry;
            out_tag     <= src_tag;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: behavioural ALU stub, scoreboard
// fed on accepted commands, monitor comparing every consumed result.
`timescale 1ns/1ps
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int W     = 32;
    localparam int SW    = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_y;
    logic [SW-1:0] in_sel;
    logic [TW-1:0] in_tag;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_y;
    logic [SW-1:0] alu_sel;
    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry;
    logic          out_divzero;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0]  result;
        logic          carry;
        logic          divzero;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_issue_queue #(
        .WORDSIZE  (W),
        .SEL_WIDTH (SW),
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_y        (in_y),
        .in_sel      (in_sel),
        .in_tag      (in_tag),
        .alu_a       (alu_a),
        .alu_y       (alu_y),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_carry   (out_carry),
        .out_divzero (out_divzero),
        .out_tag     (out_tag),
        .count       (count)
    );

    // Behavioural ALU: {carry, result}. Non-ADD carry is deliberately junk so masking is observable.
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] y,
                                          input logic [SW-1:0] sel);
        logic [W-1:0] r;
        logic         c;
        int           sh;
        sh = int'(y[4:0]);
        c  = ^a;
        r  = '0;
        case (sel)
            ALU_ADD:  {c, r} = {1'b0, a} + {1'b0, y};
            ALU_SUB:  r = a - y;
            ALU_MUL:  r = a * y;
            ALU_DIV:  r = (y == 0) ? '0 : a / y;
            ALU_SHL:  r = a << sh;
            ALU_SHR:  r = a >> sh;
            ALU_ROL:  r = (a << sh) | (a >> (W - sh));
            ALU_ROR:  r = (a >> sh) | (a << (W - sh));
            ALU_AND:  r = a & y;
            ALU_OR:   r = a | y;
            ALU_NOR:  r = ~(a | y);
            ALU_NAND: r = ~(a & y);
            ALU_XOR:  r = a ^ y;
            ALU_XNOR: r = ~(a ^ y);
            ALU_GT:   r = (a > y) ? 1 : 0;
            ALU_EQ:   r = (a == y) ? 1 : 0;
            default:  r = '0;
        endcase
        return {c, r};
    endfunction

    always_comb {alu_carry, alu_result} = alu_fn(alu_a, alu_y, alu_sel);

    // Expected output for an accepted command.
    function automatic exp_t predict(input alu_cmd_t c);
        logic [W:0] r;
        exp_t       e;
        r         = alu_fn(c.a, c.y, c.sel);
        e.divzero = (c.sel == ALU_DIV) && (c.y == 0);
        e.result  = e.divzero ? 32'hFFFF_FFFF : r[W-1:0];
        e.carry   = (c.sel == ALU_ADD) ? r[W] : 1'b0;
        e.tag     = c.tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare consumed results, verify stall stability, record accepted commands.
    bit            hold_pend = 1'b0;
    logic [W-1:0]  hold_result;
    logic [TW-1:0] hold_tag;
    logic          hold_carry;
    logic          hold_dz;

    always @(negedge clk) begin
        exp_t     e;
        alu_cmd_t c;
        if (rst === 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid",   out_valid,   1'b1);
                check("hold_result",  out_result,  hold_result);
                check("hold_tag",     out_tag,     hold_tag);
                check("hold_carry",   out_carry,   hold_carry);
                check("hold_divzero", out_divzero, hold_dz);
            end
            hold_pend   = (out_valid === 1'b1) && (out_ready === 1'b0);
            hold_result = out_result;
            hold_tag    = out_tag;
            hold_carry  = out_carry;
            hold_dz     = out_divzero;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result",  out_result,  e.result);
                    check("sb_carry",   out_carry,   e.carry);
                    check("sb_divzero", out_divzero, e.divzero);
                    check("sb_tag",     out_tag,     e.tag);
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                c.a = in_a; c.y = in_y; c.sel = in_sel; c.tag = in_tag;
                sb_q.push_back(predict(c));
            end
        end
    end

    task automatic set_idle();
        in_valid = 1'b0;
        in_a     = '0;
        in_y     = '0;
        in_sel   = '0;
        in_tag   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] y,
                            input logic [SW-1:0] sel, input logic [TW-1:0] tag);
        bit acc;
        acc      = 1'b0;
        in_a     = a;
        in_y     = y;
        in_sel   = sel;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_tag(input logic [TW-1:0] tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid === 1'b1 && out_tag === tag) seen = 1'b1;
            else tick();
        end
        check("wait_tag_seen", seen, 1'b1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            if (sb_q.size() == 0 && out_valid === 1'b0) done = 1'b1;
            else tick();
        end
        check("drain_done", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        set_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid,   1'b0);
        check("rst_count",     count,       0);
        check("rst_in_ready",  in_ready,    1'b1);
        check("rst_result",    out_result,  0);
        check("rst_carry",     out_carry,   1'b0);
        check("rst_divzero",   out_divzero, 1'b0);
        check("rst_tag",       out_tag,     0);
        check("idle_alu_a",    alu_a,       0);

        // Single ADD with carry-out and latency check
        in_a = 32'hFFFF_FFFF; in_y = 32'd1; in_sel = ALU_ADD; in_tag = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        check("add_lat_valid", out_valid, 1'b1);
        check("add_lat_count", count, 0);
`else
        check("add_lat_early", out_valid, 1'b0);
        check("add_head_a",    alu_a,     32'hFFFF_FFFF);
        check("add_head_sel",  alu_sel,   ALU_ADD);
        tick();
        check("add_lat_valid", out_valid, 1'b1);
`endif
        check("add_result", out_result, 0);
        check("add_carry",  out_carry,  1'b1);
        check("add_tag",    out_tag,    4'd3);
        wait_drain();

        // Divide by zero then a normal divide
        push_cmd(32'd100, 32'd0, ALU_DIV, 4'd4);
        wait_tag(4'd4);
        check("div0_result",  out_result,  32'hFFFF_FFFF);
        check("div0_divzero", out_divzero, 1'b1);
        push_cmd(32'd100, 32'd7, ALU_DIV, 4'd5);
        wait_tag(4'd5);
        check("div7_result",  out_result,  32'd14);
        check("div7_divzero", out_divzero, 1'b0);
        wait_drain();

        // Fill: one op in the output stage, DEPTH in the FIFO
        out_ready = 1'b0;
        for (int t = 0; t < DEPTH + 1; t++)
            push_cmd($urandom, $urandom, SW'($urandom_range(0, 15)), TW'(t));
        check("full_count",    count,    DEPTH);
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_tag = 4'd12;
        tick();
        tick();
        in_valid = 1'b0;
        check("full_no_push", count, DEPTH);
        out_ready = 1'b1;
        for (int t = 0; t < DEPTH + 1; t++) begin
            check("drain_valid", out_valid, 1'b1);
            check("drain_tag",   out_tag,   TW'(t));
            tick();
        end
        check("drain_empty", out_valid, 1'b0);

        // Continuous SUB stream at one result per cycle
        for (int i = 0; i < 20; i++) begin
            in_a = $urandom; in_y = $urandom; in_sel = ALU_SUB; in_tag = TW'(i); in_valid = 1'b1;
            tick();
            check("stream_count_le1", count <= 1, 1'b1);
            if (i >= 1) check("stream_valid", out_valid, 1'b1);
        end
        set_idle();
        wait_drain();

        // Bypass / idle latency with AND
        in_a = 32'hF0; in_y = 32'h3C; in_sel = ALU_AND; in_tag = 4'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        check("and_bypass_valid", out_valid, 1'b1);
        check("and_bypass_count", count, 0);
`else
        check("and_early_valid", out_valid, 1'b0);
        check("and_early_count", count, 1);
        tick();
        check("and_valid", out_valid, 1'b1);
`endif
        check("and_result", out_result, 32'h30);
        wait_drain();

        // Randomised traffic with back-pressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + W'($urandom_range(0, 15)) : $urandom;
            in_y      = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : $urandom;
            in_sel    = SW'($urandom_range(0, 15));
            in_tag    = TW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        set_idle();
        out_ready = 1'b1;
        wait_drain();

        // Reset with work in flight
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++)
            push_cmd(32'h1234_5678 + W'(t), 32'd3, ALU_ADD, TW'(t + 7));
        check("pre_rst_count", count,     3);
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check("mid_rst_count",   count,       0);
        check("mid_rst_valid",   out_valid,   1'b0);
        check("mid_rst_ready",   in_ready,    1'b1);
        check("mid_rst_result",  out_result,  0);
        check("mid_rst_carry",   out_carry,   1'b0);
        check("mid_rst_divzero", out_divzero, 1'b0);
        check("mid_rst_tag",     out_tag,     0);
        out_ready = 1'b1;
        tick();
        check("post_rst_idle", out_valid, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the combinational 32-bit ALU (alu1).
- Accepts operation commands {a, y, alu_sel, tag} on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU operand/select lines and captures the ALU result into a registered valid/ready output stage, tagged and with status flags.

Parameters:
- WORDSIZE, 32, operand/result width; matches the ALU wordsize.
- SEL_WIDTH, 4, opcode width; matches the ALU sel_line_size.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_WIDTH, 4, width of the caller-supplied tag carried with each op.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  high when the FIFO can accept a command.
- in_a  in  WORDSIZE  operand a.
- in_y  in  WORDSIZE  operand y.
- in_sel  in  SEL_WIDTH  ALU opcode.
- in_tag  in  TAG_WIDTH  command tag.
- alu_a  out  WORDSIZE  to ALU a.
- alu_y  out  WORDSIZE  to ALU y.
- alu_sel  out  SEL_WIDTH  to ALU alu_sel.
- alu_result  in  WORDSIZE  from ALU alu_out.
- alu_carry  in  1  from ALU carryout.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_result  out  WORDSIZE  registered result.
- out_carry  out  1  carry; meaningful for ADD only, else 0.
- out_divzero  out  1  division by zero flagged.
- out_tag  out  TAG_WIDTH  tag of the op that produced the result.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at edge): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_result=0, out_carry=0, out_divzero=0, out_tag=0. rst overrides all pushes and pops in the same edge; in-flight entries are discarded.
- in_ready = (count != DEPTH). Registered-state only; no combinational path from out_ready.
- push = in_valid & in_ready.
- load = (count != 0) & (!out_valid | out_ready).
- pop = load.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Full FIFO: in_ready=0. A pop while full does not admit a same-cycle push.
- alu_a/alu_y/alu_sel are driven combinationally from the head entry. When the FIFO is empty they are driven to all zeros.
- Output stage states:
  - EMPTY (out_valid=0) -> FULL on load.
  - FULL & out_ready & !load -> EMPTY.
  - FULL & out_ready & load -> FULL with new data (back-to-back, one result per cycle).
  - FULL & !out_ready: hold; all out_* stable.
- On load:
  - out_result = alu_result, except when head sel=0011 and head y=0: out_result = all ones, out_divzero=1.
  - out_divzero = 0 otherwise.
  - out_carry = alu_carry if head sel=0000, else 0.
  - out_tag = head tag.
- Latency: push at edge E0 into an empty queue with empty output stage gives out_valid=1 after edge E1 (2 edges).
- Ordering: strict FIFO; results emerge in command order.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined:
  - When count==0 and (!out_valid | out_ready), alu_a/alu_y/alu_sel are driven from in_a/in_y/in_sel.
  - A pushing command is loaded directly into the output stage without entering the FIFO; count stays 0.
  - Latency is 1 edge.
  - Divzero and carry rules apply to the bypassed command.
- Undefined:
  - No bypass path; latency is always at least 2 edges.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ALU_ADD=0000, ALU_SUB=0001, ALU_MUL=0010, ALU_DIV=0011, ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR, ALU_AND, ALU_OR, ALU_NOR, ALU_NAND, ALU_XOR, ALU_XNOR, ALU_GT=1110, ALU_EQ=1111.
  - Default WORDSIZE/SEL_WIDTH.
  - Packed struct alu_cmd_t {a, y, sel, tag}.
- One sub-module: alu_issue_fifo (storage, pointers, count, full/empty).
- The ALU is instantiated at the parent level, not inside this block.

Test Plan:
- Single ADD a=32'hFFFF_FFFF, y=1, tag=3, out_ready=1 -> out_valid 2 edges after push, out_result=0, out_carry=1, out_tag=3.
- DIV a=100, y=0 -> out_result=32'hFFFF_FFFF, out_divzero=1; next DIV a=100, y=7 -> out_result=14, out_divzero=0.
- out_ready=0, push 5 ops (DEPTH=4) -> 1 sits in the output stage, 4 fill the FIFO: count=4, in_ready=0. Release out_ready -> tags emerge in order 0..4, one per cycle.
- Continuous push with out_ready=1, SUB stream -> sustained one result per cycle, count stays ≤1.
- rst asserted with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, all out_* zero.
- With ALU_ISSUE_BYPASS_EN, AND a=F0, y=3C into an idle queue -> out_result=30 after 1 edge, count stays 0.
